// File: rtl/io_port_arbiter.sv
// Round-robin arbiter sharing the I/O port bank between NREQ masters.
// Owns the output port registers; input ports are sampled on granted reads.
module io_port_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned NPORTS   = 16,
    parameter int unsigned DW       = 8,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [NREQ*4-1:0]    req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    input  logic [NPORTS*DW-1:0] in_ports,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rd_valid,
    output logic [DW-1:0]        rd_data,
    output logic [NPORTS*DW-1:0] out_ports,
    output logic                 busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned HW = $clog2(LOCK_MAX + 1);

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    state_e                state_q, state_d;
    logic [NREQ-1:0]       gnt_q, gnt_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [NREQ-1:0]       rd_valid_q, rd_valid_d;
    logic [DW-1:0]         rd_data_q, rd_data_d;
    logic [NPORTS*DW-1:0]  out_q, out_d;

    logic                  win_found;
    logic [PW-1:0]         win_idx;
    logic [PW-1:0]         cand;

    logic                  g_req;
    logic                  g_we;
    logic                  g_lock;
    logic [3:0]            g_addr;
    logic [DW-1:0]         g_wdata;
    logic [DW-1:0]         rd_mux;

    // Scan from the requester after the last winner, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand = PW'((32'(ptr_q) + off) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // While granted, ptr_q holds the owner index.
    always_comb begin
        g_req   = req[ptr_q];
        g_we    = req_we[ptr_q];
        g_lock  = req_lock[ptr_q];
        g_addr  = req_addr[int'(ptr_q)*4 +: 4];
        g_wdata = req_wdata[int'(ptr_q)*DW +: DW];
    end

    // Addresses beyond the bank match no port and read as zero.
    always_comb begin
        rd_mux = '0;
        for (int unsigned p = 0; p < NPORTS; p++) begin
            if (32'(g_addr) == p) begin
                rd_mux = in_ports[p*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        rd_valid_d = '0;
        rd_data_d  = rd_data_q;
        out_d      = out_q;

        case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d = StGrant;
                    gnt_d   = NREQ'(1) << win_idx;
                    ptr_d   = win_idx;
                    hold_d  = '0;
                end
            end
            StGrant: begin
                state_d = StIdle;
                gnt_d   = '0;
                if (g_req) begin
                    if (g_we) begin
                        for (int unsigned p = 0; p < NPORTS; p++) begin
                            if (32'(g_addr) == p) begin
                                out_d[p*DW +: DW] = g_wdata;
                            end
                        end
                    end else begin
                        rd_valid_d = gnt_q;
                        rd_data_d  = rd_mux;
                    end
                    // Watchdog: a locked burst is capped at LOCK_MAX accesses.
                    if (g_lock && (hold_q < HW'(LOCK_MAX - 1))) begin
                        state_d = StGrant;
                        gnt_d   = gnt_q;
                        hold_d  = hold_q + HW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            ptr_q      <= PW'(NREQ - 1);
            hold_q     <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            out_q      <= out_d;
        end
    end

    assign gnt       = gnt_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign out_ports = out_q;
    assign busy      = (state_q == StGrant);

endmodule

// File: tb/tb_io_port_arbiter.sv
// Bench for io_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_io_port_arbiter;

    localparam int NREQ     = 4;
    localparam int NPORTS   = 16;
    localparam int DW       = 8;
    localparam int LOCK_MAX = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req, req_we, req_lock;
    logic [NREQ*4-1:0]    req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NPORTS*DW-1:0] in_ports;
    logic [NREQ-1:0]      gnt, rd_valid;
    logic [DW-1:0]        rd_data;
    logic [NPORTS*DW-1:0] out_ports;
    logic                 busy;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: current owner (-1 = none), last winner, accesses in current grant.
    int                   m_owner, m_last, m_burst, m_acc;
    logic [NPORTS*DW-1:0] m_out;
    logic [NREQ-1:0]      m_rdv;
    logic [DW-1:0]        m_rdd;

    io_port_arbiter #(
        .NREQ(NREQ), .NPORTS(NPORTS), .DW(DW), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .in_ports(in_ports), .gnt(gnt),
        .rd_valid(rd_valid), .rd_data(rd_data), .out_ports(out_ports), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic lock, input logic [3:0] addr,
                           input logic [DW-1:0] wd);
        req[i] = 1'b1; req_we[i] = we; req_lock[i] = lock;
        req_addr[i*4 +: 4] = addr; req_wdata[i*DW +: DW] = wd;
    endtask

    task automatic reset_pulse();
        idle_inputs();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req = '1; req_we = 4'b1010; req_lock = '1;
        req_addr = 16'h3c5a; req_wdata = 32'hdeadbeef;
        in_ports = {$urandom, $urandom, $urandom, $urandom};
        cyc();
        vectors++; if (gnt !== 4'b0) begin miscompares++; $display("FAIL reset gnt: got %b expected 0000", gnt); end
        vectors++; if (rd_valid !== 4'b0) begin miscompares++; $display("FAIL reset rd_valid: got %b expected 0000", rd_valid); end
        vectors++; if (rd_data !== 8'h0) begin miscompares++; $display("FAIL reset rd_data: got %h expected 00", rd_data); end
        vectors++; if (out_ports !== '0) begin miscompares++; $display("FAIL reset out_ports: got %h expected 0", out_ports); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b expected 0", busy); end
        reset = 1'b1;
        idle_inputs();
        cyc(); cyc();
        vectors++; if (gnt !== 4'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle gnt/busy: got %b/%b expected 0000/0", gnt, busy); end
    endtask

    task automatic test_single_write();
        set_req(0, 1'b1, 1'b0, 4'd3, 8'hAA);
        cyc();
        vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL write gnt: got %b expected 0001", gnt); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL write busy: got %b expected 1", busy); end
        vectors++; if (out_ports[3*DW +: DW] !== 8'h00) begin miscompares++; $display("FAIL write early port3: got %h expected 00", out_ports[3*DW +: DW]); end
        cyc();
        idle_inputs();
        vectors++; if (out_ports !== (128'hAA << 24)) begin miscompares++; $display("FAIL write out_ports: got %h expected %h", out_ports, 128'hAA << 24); end
        vectors++; if (gnt !== 4'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL write bubble gnt/busy: got %b/%b expected 0000/0", gnt, busy); end
        vectors++; if (rd_valid !== 4'b0) begin miscompares++; $display("FAIL write rd_valid: got %b expected 0000", rd_valid); end
        cyc();
    endtask

    task automatic test_read();
        in_ports[1*DW +: DW] = 8'h44;
        set_req(2, 1'b0, 1'b0, 4'd1, 8'h00);
        cyc();
        vectors++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL read gnt: got %b expected 0100", gnt); end
        vectors++; if (rd_valid !== 4'b0) begin miscompares++; $display("FAIL read early rd_valid: got %b expected 0000", rd_valid); end
        cyc();
        idle_inputs();
        vectors++; if (rd_valid !== 4'b0100) begin miscompares++; $display("FAIL read rd_valid: got %b expected 0100", rd_valid); end
        vectors++; if (rd_data !== 8'h44) begin miscompares++; $display("FAIL read rd_data: got %h expected 44", rd_data); end
        cyc();
        vectors++; if (rd_valid !== 4'b0 || rd_data !== 8'h44) begin miscompares++; $display("FAIL read hold: got %b/%h expected 0000/44", rd_valid, rd_data); end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] eg;
        int r;
        reset_pulse();
        in_ports = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 4'(i), 8'h00);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            eg = (k % 2 == 1) ? (4'b0001 << (((k - 1) / 2) % 4)) : 4'b0000;
            vectors++; if (gnt !== eg) begin miscompares++; $display("FAIL rr gnt cycle %0d: got %b expected %b", k, gnt, eg); end
            if (k % 2 == 0) begin
                r = ((k - 2) / 2) % 4;
                vectors++; if (rd_valid !== (4'b0001 << r) || rd_data !== in_ports[r*DW +: DW]) begin
                    miscompares++;
                    $display("FAIL rr read cycle %0d: got %b/%h expected %b/%h", k, rd_valid, rd_data, 4'b0001 << r, in_ports[r*DW +: DW]);
                end
            end
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_lock_watchdog();
        reset_pulse();
        set_req(1, 1'b1, 1'b1, 4'd5, 8'h5A);
        set_req(3, 1'b0, 1'b0, 4'd2, 8'h00);
        for (int k = 1; k <= LOCK_MAX; k++) begin
            cyc();
            vectors++; if (gnt !== 4'b0010) begin miscompares++; $display("FAIL lock gnt cycle %0d: got %b expected 0010", k, gnt); end
        end
        cyc();
        vectors++; if (gnt !== 4'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL watchdog release: got %b/%b expected 0000/0", gnt, busy); end
        vectors++; if (out_ports[5*DW +: DW] !== 8'h5A) begin miscompares++; $display("FAIL lock port5: got %h expected 5a", out_ports[5*DW +: DW]); end
        cyc();
        vectors++; if (gnt !== 4'b1000) begin miscompares++; $display("FAIL watchdog next gnt: got %b expected 1000", gnt); end
        cyc();
        vectors++; if (rd_valid !== 4'b1000 || rd_data !== in_ports[2*DW +: DW]) begin
            miscompares++;
            $display("FAIL watchdog read: got %b/%h expected 1000/%h", rd_valid, rd_data, in_ports[2*DW +: DW]);
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_midop_reset();
        set_req(0, 1'b1, 1'b0, 4'd7, 8'h77);
        cyc();
        vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL midreset gnt: got %b expected 0001", gnt); end
        reset = 1'b0;
        cyc();
        vectors++; if (gnt !== 4'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL midreset gnt/busy: got %b/%b expected 0000/0", gnt, busy); end
        vectors++; if (out_ports !== '0 || rd_valid !== 4'b0) begin miscompares++; $display("FAIL midreset out/rdv: got %h/%b expected 0/0000", out_ports, rd_valid); end
        reset = 1'b1;
        idle_inputs();
        cyc();
        vectors++; if (out_ports[7*DW +: DW] !== 8'h00) begin miscompares++; $display("FAIL midreset port7: got %h expected 00", out_ports[7*DW +: DW]); end
    endtask

    task automatic new_txn(input int i);
        set_req(i, 1'($urandom % 2), 1'($urandom % 3 == 0), 4'($urandom % 16), 8'($urandom));
    endtask

    // Transaction-level reference: who owns the bank and what each access does.
    task automatic model_step();
        logic [3:0] a;
        m_rdv = '0;
        m_acc = -1;
        if (m_owner < 0) begin
            for (int off = 1; off <= NREQ; off++) begin
                if (m_owner < 0 && req[(m_last + off) % NREQ]) begin
                    m_owner = (m_last + off) % NREQ;
                    m_last  = m_owner;
                    m_burst = 0;
                end
            end
        end else if (req[m_owner]) begin
            m_acc = m_owner;
            m_burst++;
            a = req_addr[m_owner*4 +: 4];
            if (req_we[m_owner]) begin
                if (a < NPORTS) m_out[a*DW +: DW] = req_wdata[m_owner*DW +: DW];
            end else begin
                m_rdv[m_owner] = 1'b1;
                m_rdd = (a < NPORTS) ? in_ports[a*DW +: DW] : '0;
            end
            if (!(req_lock[m_owner] && m_burst < LOCK_MAX)) m_owner = -1;
        end else begin
            m_owner = -1;
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] eg;
        reset_pulse();
        m_owner = -1; m_last = NREQ - 1; m_burst = 0; m_acc = -1;
        m_out = '0; m_rdv = '0; m_rdd = '0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_acc == i) begin
                    if ($urandom % 4 != 0) new_txn(i);
                    else req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom % 4 == 0) new_txn(i);
                end else if (m_owner == i && $urandom % 16 == 0) begin
                    req[i] = 1'b0;
                end
            end
            in_ports = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            model_step();
            #1;
            eg = (m_owner < 0) ? '0 : (NREQ'(1) << m_owner);
            vectors++; if (gnt !== eg) begin miscompares++; $display("FAIL rand gnt cycle %0d: got %b expected %b", n, gnt, eg); end
            vectors++; if (busy !== (m_owner >= 0)) begin miscompares++; $display("FAIL rand busy cycle %0d: got %b expected %b", n, busy, m_owner >= 0); end
            vectors++; if (rd_valid !== m_rdv) begin miscompares++; $display("FAIL rand rd_valid cycle %0d: got %b expected %b", n, rd_valid, m_rdv); end
            vectors++; if (rd_data !== m_rdd) begin miscompares++; $display("FAIL rand rd_data cycle %0d: got %h expected %h", n, rd_data, m_rdd); end
            vectors++; if (out_ports !== m_out) begin miscompares++; $display("FAIL rand out_ports cycle %0d: got %h expected %h", n, out_ports, m_out); end
        end
        idle_inputs();
        cyc();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        in_ports = '0;
        test_reset();
        test_single_write();
        test_read();
        test_round_robin();
        test_lock_watchdog();
        test_midop_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
